// File: rtl/iir_biquad_mc.sv
// Time-multiplexed biquad IIR: CHANNELS streams share one multiplier, five MAC cycles per channel.
// Define IIR_BIQUAD_SATURATE_EN to clamp results and add the sat_flag output; default wraps.
module iir_biquad_mc #(
   parameter int DATA_W   = 16,
   parameter int COEF_W   = 12,
   parameter int FRAC     = 9,
   parameter int CHANNELS = 2
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic [CHANNELS*DATA_W-1:0]   xin,
   input  logic                         in_tick,
   input  logic signed [COEF_W-1:0]     b0,
   input  logic signed [COEF_W-1:0]     b1,
   input  logic signed [COEF_W-1:0]     b2,
   input  logic signed [COEF_W-1:0]     a1,
   input  logic signed [COEF_W-1:0]     a2,
   output logic [CHANNELS*DATA_W-1:0]   yout,
   output logic                         out_tick,
   output logic                         busy,
   output logic                         overrun,
`ifdef IIR_BIQUAD_SATURATE_EN
   output logic                         sat_flag,
`endif
   output logic [2:0]                   o_dbg_state
);

   localparam int ACC_W  = DATA_W + COEF_W + 3;
   localparam int PROD_W = DATA_W + COEF_W;
   localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LOAD  = 3'd1;
   localparam logic [2:0] MAC   = 3'd2;
   localparam logic [2:0] WRITE = 3'd3;
   localparam logic [2:0] OUT   = 3'd4;

   // Handshake: in_tick is a one-cycle strobe accepted only in IDLE; out_tick pulses
   // for exactly one cycle while yout already carries the whole new frame.
   logic [2:0]                r_state;
   logic [CH_W-1:0]           r_ch;
   logic [2:0]                r_term;
   logic signed [ACC_W-1:0]   r_acc;
   logic signed [COEF_W-1:0]  r_b0, r_b1, r_b2, r_a1, r_a2;
   logic signed [DATA_W-1:0]  r_x0 [CHANNELS];
   logic signed [DATA_W-1:0]  r_x1 [CHANNELS];
   logic signed [DATA_W-1:0]  r_x2 [CHANNELS];
   logic signed [DATA_W-1:0]  r_y1 [CHANNELS];
   logic signed [DATA_W-1:0]  r_y2 [CHANNELS];
   logic signed [DATA_W-1:0]  r_stage [CHANNELS];
   logic [CHANNELS*DATA_W-1:0] r_yout;
   logic                      r_out_tick;
   logic                      r_overrun;
   logic                      r_sat_any;
   logic                      r_sat_flag;

   logic signed [DATA_W-1:0]  w_op;
   logic signed [COEF_W-1:0]  w_cf;
   logic signed [PROD_W-1:0]  w_prod;
   logic signed [ACC_W-1:0]   w_prod_ext;
   logic signed [DATA_W-1:0]  w_r;
   logic                      w_clip;
   logic signed [DATA_W-1:0]  w_stage_nxt [CHANNELS];
   logic [CHANNELS*DATA_W-1:0] w_yout_nxt;

   always_comb begin
      w_op = r_x0[r_ch];
      w_cf = r_b0;
      case (r_term)
         3'd0:    begin w_op = r_x0[r_ch]; w_cf = r_b0; end
         3'd1:    begin w_op = r_x1[r_ch]; w_cf = r_b1; end
         3'd2:    begin w_op = r_x2[r_ch]; w_cf = r_b2; end
         3'd3:    begin w_op = r_y1[r_ch]; w_cf = r_a1; end
         default: begin w_op = r_y2[r_ch]; w_cf = r_a2; end
      endcase
   end

   assign w_prod     = w_op * w_cf;
   assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

`ifdef IIR_BIQUAD_SATURATE_EN
   localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
   logic signed [ACC_W-1:0] w_shift;
   assign w_shift = r_acc >>> FRAC;
   always_comb begin
      w_clip = 1'b0;
      w_r    = w_shift[DATA_W-1:0];
      if (w_shift > MAX_V) begin
         w_clip = 1'b1;
         w_r    = {1'b0, {(DATA_W-1){1'b1}}};
      end else if (w_shift < MIN_V) begin
         w_clip = 1'b1;
         w_r    = {1'b1, {(DATA_W-1){1'b0}}};
      end
   end
   assign sat_flag = r_sat_flag;
`else
   assign w_r    = r_acc[FRAC+DATA_W-1:FRAC];
   assign w_clip = 1'b0;
`endif

   // Staging with the current lane replaced, flattened so OUT publishes every lane at once.
   always_comb begin
      w_yout_nxt = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         w_stage_nxt[c] = r_stage[c];
      end
      w_stage_nxt[r_ch] = w_r;
      for (int c = 0; c < CHANNELS; c++) begin
         w_yout_nxt[c*DATA_W +: DATA_W] = w_stage_nxt[c];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= IDLE;
         r_ch       <= '0;
         r_term     <= '0;
         r_acc      <= '0;
         r_b0 <= '0; r_b1 <= '0; r_b2 <= '0; r_a1 <= '0; r_a2 <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            r_x0[c] <= '0; r_x1[c] <= '0; r_x2[c] <= '0;
            r_y1[c] <= '0; r_y2[c] <= '0; r_stage[c] <= '0;
         end
         r_yout     <= '0;
         r_out_tick <= 1'b0;
         r_overrun  <= 1'b0;
         r_sat_any  <= 1'b0;
         r_sat_flag <= 1'b0;
      end else begin
         r_out_tick <= 1'b0;
         r_sat_flag <= 1'b0;
         if (in_tick && (r_state != IDLE)) r_overrun <= 1'b1;
         case (r_state)
            IDLE: if (in_tick) r_state <= LOAD;
            LOAD: begin
               for (int c = 0; c < CHANNELS; c++) r_x0[c] <= xin[c*DATA_W +: DATA_W];
               r_b0 <= b0; r_b1 <= b1; r_b2 <= b2; r_a1 <= a1; r_a2 <= a2;
               r_ch      <= '0;
               r_term    <= '0;
               r_sat_any <= 1'b0;
               r_state   <= MAC;
            end
            MAC: begin
               r_acc <= ((r_term == 3'd0) ? '0 : r_acc) + w_prod_ext;
               if (r_term == 3'd4) begin
                  r_term  <= '0;
                  r_state <= WRITE;
               end else begin
                  r_term <= r_term + 3'd1;
               end
            end
            WRITE: begin
               r_x2[r_ch] <= r_x1[r_ch];
               r_x1[r_ch] <= r_x0[r_ch];
               r_y2[r_ch] <= r_y1[r_ch];
               r_y1[r_ch] <= w_r;
               for (int c = 0; c < CHANNELS; c++) r_stage[c] <= w_stage_nxt[c];
               r_sat_any <= r_sat_any | w_clip;
               if (r_ch == LAST_CH) begin
                  r_yout     <= w_yout_nxt;
                  r_out_tick <= 1'b1;
                  r_sat_flag <= r_sat_any | w_clip;
                  r_state    <= OUT;
               end else begin
                  r_ch    <= r_ch + 1'b1;
                  r_state <= MAC;
               end
            end
            OUT:     r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign yout        = r_yout;
   assign out_tick    = r_out_tick;
   assign busy        = (r_state != IDLE);
   assign overrun     = r_overrun;
   assign o_dbg_state = r_state;

endmodule

// File: doc/iir_biquad_mc.md
Name: iir_biquad_mc

Overview:
- Parametrised, time-multiplexed second-order IIR (biquad) section for the post-demod audio path. Typical uses: 19 kHz pilot bandpass, 38 kHz subcarrier filtering, de-emphasis.
- Coefficients are runtime ports, so one block serves every filter shape.
- CHANNELS independent streams (e.g. L/R or L+R/L−R) share a single multiplier, serviced sequentially per input tick.
- Sits between the FM demodulator/decimator (500 kHz tick domain) and the stereo decoder.

Parameters:
- DATA_W, 16, sample width (signed) of xin lanes and yout lanes
- COEF_W, 12, coefficient width (signed)
- FRAC, 9, coefficient fractional bits; result is accumulator arithmetically shifted right by FRAC
- CHANNELS, 2, number of independent channels (1..8)

Ports:
- CLK  in  1  system clock (100 MHz)
- RST  in  1  synchronous reset, active-high
- xin  in  CHANNELS*DATA_W  packed signed inputs; channel c at bits [c*DATA_W +: DATA_W]
- in_tick  in  1  one-cycle strobe: xin valid
- b0, b1, b2  in  COEF_W each  signed feed-forward coefficients
- a1, a2  in  COEF_W each  signed feedback coefficients, added (not subtracted)
- yout  out  CHANNELS*DATA_W  packed signed outputs, same lane layout as xin
- out_tick  out  1  one-cycle strobe: yout updated
- busy  out  1  high from LOAD through OUT
- overrun  out  1  sticky: in_tick arrived while busy

Behaviour:
- Per channel: acc = b0*x[n] + b1*x[n-1] + b2*x[n-2] + a1*y[n-1] + a2*y[n-2].
- acc width ACC_W = DATA_W+COEF_W+3. Full-precision signed products, no intermediate truncation.
- Result r = acc >>> FRAC (floor, no rounding). The y[n] fed back as history is the same value driven on yout (post saturate/wrap).
- FSM states: IDLE, LOAD, MAC, WRITE, OUT.
  - IDLE: leave on in_tick=1.
  - LOAD (1 cycle): latch all xin lanes and snapshot all five coefficients. Coefficient changes mid-frame are ignored. Channel index ch=0.
  - MAC (5 cycles, term index 0..4): accumulate one product per cycle. acc is cleared on the first term.
  - WRITE (1 cycle): shift channel histories (x2<=x1, x1<=x0, y2<=y1, y1<=r) and store r into a staging register. If ch<CHANNELS-1, ch++ and go to MAC; else go to OUT.
  - OUT (1 cycle): copy all staging registers to yout at once, pulse out_tick, return to IDLE.
- Latency: in_tick high in cycle 0 → out_tick high in cycle 2+6*CHANNELS (14 for CHANNELS=2). Throughput: one frame per 3+6*CHANNELS cycles.
- yout holds its value between out_ticks. Lanes never update partially.
- in_tick while busy=1 (including in OUT): sample dropped, overrun<=1, no other effect. in_tick in IDLE on the cycle after OUT is accepted normally.
- overrun clears only on RST.
- RST (any state, including mid-MAC): state<=IDLE, all x/y histories, acc, staging and yout <=0, out_tick<=0, busy<=0, overrun<=0. An in-flight frame is discarded. RST has priority over in_tick in the same cycle.
- Reset values: yout=0, out_tick=0, busy=0, overrun=0.

Optional Feature:
- Macro IIR_BIQUAD_SATURATE_EN.
- Defined: r is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1] before history write/yout. Adds output sat_flag (1 bit): pulses with out_tick when any lane clipped in that frame; reset 0.
- Undefined: r is taken as acc[FRAC+DATA_W-1:FRAC] (two's-complement wrap). No sat_flag port.

Test Plan:
- Pilot BPF impulse, CHANNELS=2, b0=2, b1=0, b2=-2, a1=993, a2=-510: ch0 x=1000 then 0, ch1 x=0 → ch0 y=3 then 5; ch1 y=0 both frames (channel isolation).
- Passthrough b0=512, others 0, ch0=-1234, ch1=777 → out_tick exactly 14 cycles after in_tick, yout lanes -1234/777, busy high for cycles 1..14.
- Overflow b0=2047, others 0, x=32767 → with macro y=32767 and sat_flag=1; without macro y=-68.
- Overrun: second in_tick 3 cycles after first → overrun=1, only one out_tick, histories advanced once. Next in_tick after OUT is processed normally.
- Reset mid-frame: assert RST during MAC term 2 of ch1 → no out_tick, yout=0, overrun=0. Passthrough frame afterwards gives exact input values (histories zero).
- Coefficient change during MAC (b0 512→0) → current frame uses 512, next frame uses 0.
